// File: rtl/nrisc_isa_pkg.sv
// nRISC 8-bit ISA definitions shared by the program loader, decoder and sign extender.
package nrisc_isa_pkg;

  localparam int unsigned InstrW = 8;

  // Opcodes, always in instruction bits [7:5]
  localparam logic [2:0] OpLoad  = 3'b000;
  localparam logic [2:0] OpStore = 3'b001;
  localparam logic [2:0] OpAdd   = 3'b010;
  localparam logic [2:0] OpAddi  = 3'b011;
  localparam logic [2:0] OpBeq   = 3'b100;
  localparam logic [2:0] OpSlt   = 3'b101;
  localparam logic [2:0] OpJump  = 3'b110;
  localparam logic [2:0] OpHalt  = 3'b111;

  // Field bit positions
  localparam int unsigned OpMsb   = 7;
  localparam int unsigned OpLsb   = 5;
  localparam int unsigned RaMsb   = 4;
  localparam int unsigned RaLsb   = 3;
  localparam int unsigned RbMsb   = 2;
  localparam int unsigned RbLsb   = 1;
  localparam int unsigned ImmIMsb = 2;
  localparam int unsigned ImmJMsb = 4;

  // Representable immediate ranges per format
  localparam int ImmIMin = -4;
  localparam int ImmIMax = 3;
  localparam int ImmJMin = -16;
  localparam int ImmJMax = 15;

  // Loader error codes
  localparam logic [1:0] ErrNone     = 2'b00;
  localparam logic [1:0] ErrImmRange = 2'b01;
  localparam logic [1:0] ErrOverflow = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWrite,
    StDone,
    StError
  } loader_state_e;

  typedef enum logic [1:0] {
    FmtI,
    FmtR,
    FmtJ,
    FmtHalt
  } instr_fmt_e;

  function automatic instr_fmt_e op_format(input logic [2:0] op);
    case (op)
      OpAdd, OpSlt: return FmtR;
      OpJump:       return FmtJ;
      OpHalt:       return FmtHalt;
      default:      return FmtI;
    endcase
  endfunction

  // Sign extender views of the immediate fields
  function automatic logic [7:0] sext_imm_i(input logic [7:0] word);
    return {{(8 - ImmIMsb - 1){word[ImmIMsb]}}, word[ImmIMsb:0]};
  endfunction

  function automatic logic [7:0] sext_imm_j(input logic [7:0] word);
    return {{(8 - ImmJMsb - 1){word[ImmJMsb]}}, word[ImmJMsb:0]};
  endfunction

endpackage

// File: rtl/nrisc_program_loader_if.sv
// Field-set handshake plus instruction-memory write port of the program loader.
interface nrisc_program_loader_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [1:0]        in_ra;
  logic [1:0]        in_rb;
  logic [7:0]        in_imm;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;

  // Host / assembler side
  modport master (
    output in_valid, in_op, in_ra, in_rb, in_imm,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  // Loader side
  modport slave (
    input  in_valid, in_op, in_ra, in_rb, in_imm,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/nrisc_instr_encoder.sv
// Packs decoded fields into an 8-bit nRISC word and flags unrepresentable immediates.
module nrisc_instr_encoder
  import nrisc_isa_pkg::*;
(
  input  logic [2:0] op,
  input  logic [1:0] ra,
  input  logic [1:0] rb,
  input  logic [7:0] imm,
  output logic [7:0] word,
  output logic       imm_ok
);

  int imm_val;

  assign imm_val = int'($signed(imm));

  // Format-dependent packing; range check equals "sign-extended field == imm"
  always_comb begin
    word = '0;
    imm_ok = 1'b1;
    word[OpMsb:OpLsb] = op;
    unique case (op_format(op))
      FmtI: begin
        word[RaMsb:RaLsb] = ra;
        word[ImmIMsb:0] = imm[ImmIMsb:0];
        imm_ok = (imm_val >= ImmIMin) && (imm_val <= ImmIMax);
      end
      FmtR: begin
        word[RaMsb:RaLsb] = ra;
        word[RbMsb:RbLsb] = rb;
      end
      FmtJ: begin
        word[ImmJMsb:0] = imm[ImmJMsb:0];
        imm_ok = (imm_val >= ImmJMin) && (imm_val <= ImmJMax);
      end
      FmtHalt: ;
      default: ;
    endcase
  end

endmodule

// File: rtl/nrisc_program_loader.sv
// Accepts field sets, encodes them and writes sequential instruction memory from address 0.
module nrisc_program_loader
  import nrisc_isa_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  nrisc_program_loader_if.slave bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [1:0]           err_code,
  output logic [ADDR_W:0]      count
);

  localparam int unsigned CntW = ADDR_W + 1;

  loader_state_e     state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CntW-1:0]   count_q;
  logic [7:0]        wdata_q;
  logic [1:0]        err_code_q;
  logic              halt_q;

  logic [7:0] enc_word;
  logic       enc_imm_ok;

  nrisc_instr_encoder u_encoder (
    .op     (bus.in_op),
    .ra     (bus.in_ra),
    .rb     (bus.in_rb),
    .imm    (bus.in_imm),
    .word   (enc_word),
    .imm_ok (enc_imm_ok)
  );

  // Loader FSM with address, count, data and error registers; start overrides every state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      count_q    <= '0;
      wdata_q    <= '0;
      err_code_q <= ErrNone;
      halt_q     <= 1'b0;
    end else if (start) begin
      state_q    <= StLoad;
      addr_q     <= '0;
      count_q    <= '0;
      err_code_q <= ErrNone;
    end else begin
      unique case (state_q)
        StIdle: ;
        StLoad: begin
          if (bus.in_valid) begin
            if (enc_imm_ok) begin
              wdata_q <= enc_word;
              halt_q  <= (bus.in_op == OpHalt);
              state_q <= StWrite;
            end else begin
              err_code_q <= ErrImmRange;
              state_q    <= StError;
            end
          end
        end
        StWrite: begin
          count_q <= count_q + CntW'(1);
          if (halt_q) begin
            state_q <= StDone;
          end else if (&addr_q) begin
            // Last location was just written; nowhere left for the next word
            err_code_q <= ErrOverflow;
            state_q    <= StError;
          end else begin
            addr_q  <= addr_q + ADDR_W'(1);
            state_q <= StLoad;
          end
        end
        StDone, StError: ;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Status and strobes are pure state decodes so reset clears them immediately
  assign bus.in_ready  = (state_q == StLoad);
  assign bus.mem_we    = (state_q == StWrite);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign busy          = (state_q == StLoad) || (state_q == StWrite);
  assign done          = (state_q == StDone);
  assign err           = (state_q == StError);
  assign err_code      = err_code_q;
  assign count         = count_q;

endmodule

// File: tb/tb_nrisc_program_loader.sv
// Self-checking bench: two loaders (ADDR_W 8 and 2), scoreboard of expected memory writes.
module tb_nrisc_program_loader;
  import nrisc_isa_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start1, start2, valid1, valid2;
  logic [2:0] op;
  logic [1:0] ra, rb;
  logic [7:0] imm;

  logic       busy1, done1, err1, busy2, done2, err2;
  logic [1:0] err_code1, err_code2;
  logic [8:0] count1;
  logic [2:0] count2;

  nrisc_program_loader_if #(.ADDR_W(8)) bus1 ();
  nrisc_program_loader_if #(.ADDR_W(2)) bus2 ();

  assign bus1.in_valid = valid1;
  assign bus1.in_op    = op;
  assign bus1.in_ra    = ra;
  assign bus1.in_rb    = rb;
  assign bus1.in_imm   = imm;
  assign bus2.in_valid = valid2;
  assign bus2.in_op    = op;
  assign bus2.in_ra    = ra;
  assign bus2.in_rb    = rb;
  assign bus2.in_imm   = imm;

  nrisc_program_loader #(.ADDR_W(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .bus(bus1),
    .busy(busy1), .done(done1), .err(err1), .err_code(err_code1), .count(count1)
  );

  nrisc_program_loader #(.ADDR_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .bus(bus2),
    .busy(busy2), .done(done2), .err(err2), .err_code(err_code2), .count(count2)
  );

  int errors = 0;
  int checks = 0;
  int tcyc = 0;
  logic [15:0] q1[$];
  logic [15:0] q2[$];
  int wcyc1[$];

  // Advance to the next falling edge and score any memory write seen there
  task automatic tick();
    logic [15:0] e;
    logic [15:0] got;
    @(negedge clk);
    tcyc++;
    if (bus1.mem_we === 1'b1) begin
      got = {bus1.mem_addr, bus1.mem_wdata};
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL dut1_write unexpected got=%h want=none", got);
      end else begin
        e = q1.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL dut1_write got=%h want=%h", got, e);
        end
      end
      wcyc1.push_back(tcyc);
    end
    if (bus2.mem_we === 1'b1) begin
      got = {6'b0, bus2.mem_addr, bus2.mem_wdata};
      checks++;
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL dut2_write unexpected got=%h want=none", got);
      end else begin
        e = q2.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL dut2_write got=%h want=%h", got, e);
        end
      end
    end
  endtask

  // Offer one field set; returns just after the accepting edge
  task automatic send(input bit which, input logic [2:0] o, input logic [1:0] a,
                      input logic [1:0] b, input logic [7:0] i, input bit push,
                      input int addr, input logic [7:0] word);
    bit got;
    got = 1'b0;
    op = o; ra = a; rb = b; imm = i;
    if (push) begin
      if (which) q2.push_back({8'(addr), word});
      else q1.push_back({8'(addr), word});
    end
    if (which) valid2 = 1'b1;
    else valid1 = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if ((which ? bus2.in_ready : bus1.in_ready) === 1'b1) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    if (got) begin
      @(posedge clk);
      #1;
    end else begin
      checks++;
      errors++;
      $display("FAIL send_timeout got=no_ready want=ready dut=%0d", which);
    end
    valid1 = 1'b0;
    valid2 = 1'b0;
  endtask

  task automatic pulse_start(input bit which);
    tick();
    if (which) start2 = 1'b1;
    else start1 = 1'b1;
    tick();
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic drain(input bit which);
    for (int k = 0; k < 20; k++) begin
      if ((which ? q2.size() : q1.size()) == 0) break;
      tick();
    end
    checks++;
    if ((which ? q2.size() : q1.size()) != 0) begin
      errors++;
      $display("FAIL drain_dut%0d got=%0d_pending want=0", which, which ? q2.size() : q1.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++; if (bus1.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b want=0", bus1.in_ready); end
    checks++; if (bus1.mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got=%b want=0", bus1.mem_we); end
    checks++; if (bus1.mem_addr !== 8'd0) begin errors++; $display("FAIL rst_mem_addr got=%h want=0", bus1.mem_addr); end
    checks++; if (bus1.mem_wdata !== 8'd0) begin errors++; $display("FAIL rst_mem_wdata got=%h want=0", bus1.mem_wdata); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b want=0", busy1); end
    checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL rst_done got=%b want=0", done1); end
    checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL rst_err got=%b want=0", err1); end
    checks++; if (err_code1 !== 2'b00) begin errors++; $display("FAIL rst_err_code got=%b want=00", err_code1); end
    checks++; if (count1 !== 9'd0) begin errors++; $display("FAIL rst_count got=%0d want=0", count1); end
    checks++; if (count2 !== 3'd0) begin errors++; $display("FAIL rst_count2 got=%0d want=0", count2); end
    tick();
    rst_n = 1'b1;
    // in_valid in IDLE is ignored: no write, no error
    valid1 = 1'b1;
    repeat (3) tick();
    valid1 = 1'b0;
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b want=0", busy1); end
    checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL idle_err got=%b want=0", err1); end
  endtask

  task automatic test_program();
    pulse_start(1'b0);
    send(1'b0, OpLoad, 2'd0, 2'd0, 8'd1, 1'b1, 0, 8'b00000001);
    checks++; if (bus1.mem_we !== 1'b1) begin errors++; $display("FAIL prog_we_latency got=%b want=1", bus1.mem_we); end
    send(1'b0, OpAdd, 2'd0, 2'd2, 8'd0, 1'b1, 1, 8'b01000100);
    send(1'b0, OpBeq, 2'd2, 2'd0, 8'd0, 1'b1, 2, 8'b10010000);
    send(1'b0, OpJump, 2'd0, 2'd0, 8'd7, 1'b1, 3, 8'b11000111);
    send(1'b0, OpHalt, 2'd2, 2'd1, 8'd7, 1'b1, 4, 8'b11100000);
    drain(1'b0);
    tick();
    checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL prog_done got=%b want=1", done1); end
    checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL prog_err got=%b want=0", err1); end
    checks++; if (count1 !== 9'd5) begin errors++; $display("FAIL prog_count got=%0d want=5", count1); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL prog_busy got=%b want=0", busy1); end
    checks++; if (bus1.in_ready !== 1'b0) begin errors++; $display("FAIL prog_ready got=%b want=0", bus1.in_ready); end
  endtask

  task automatic test_imm_range();
    pulse_start(1'b0);
    send(1'b0, OpAddi, 2'd1, 2'd0, 8'hFE, 1'b1, 0, 8'b01101110);
    send(1'b0, OpAddi, 2'd1, 2'd0, 8'd4, 1'b0, 0, 8'h00);
    checks++; if (err1 !== 1'b1) begin errors++; $display("FAIL imm_err got=%b want=1", err1); end
    checks++; if (err_code1 !== 2'b01) begin errors++; $display("FAIL imm_err_code got=%b want=01", err_code1); end
    checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL imm_done got=%b want=0", done1); end
    checks++; if (bus1.mem_addr !== 8'd1) begin errors++; $display("FAIL imm_mem_addr got=%0d want=1", bus1.mem_addr); end
    checks++; if (count1 !== 9'd1) begin errors++; $display("FAIL imm_count got=%0d want=1", count1); end
    drain(1'b0);
  endtask

  task automatic test_jump_range();
    pulse_start(1'b0);
    send(1'b0, OpStore, 2'd3, 2'd0, 8'hFC, 1'b1, 0, 8'b00111100);
    send(1'b0, OpJump, 2'd0, 2'd0, 8'hF0, 1'b1, 1, 8'b11010000);
    send(1'b0, OpJump, 2'd0, 2'd0, 8'd15, 1'b1, 2, 8'b11001111);
    send(1'b0, OpJump, 2'd0, 2'd0, 8'd16, 1'b0, 0, 8'h00);
    checks++; if (err_code1 !== 2'b01) begin errors++; $display("FAIL jump_err_code got=%b want=01", err_code1); end
    checks++; if (bus1.mem_addr !== 8'd3) begin errors++; $display("FAIL jump_mem_addr got=%0d want=3", bus1.mem_addr); end
    checks++; if (count1 !== 9'd3) begin errors++; $display("FAIL jump_count got=%0d want=3", count1); end
    drain(1'b0);
  endtask

  task automatic test_overflow();
    pulse_start(1'b1);
    for (int k = 0; k < 4; k++) begin
      send(1'b1, OpAddi, 2'd0, 2'd0, 8'(k), 1'b1, k, 8'h60 | 8'(k));
    end
    drain(1'b1);
    tick();
    checks++; if (err2 !== 1'b1) begin errors++; $display("FAIL ovf_err got=%b want=1", err2); end
    checks++; if (err_code2 !== 2'b10) begin errors++; $display("FAIL ovf_err_code got=%b want=10", err_code2); end
    checks++; if (count2 !== 3'd4) begin errors++; $display("FAIL ovf_count got=%0d want=4", count2); end
    checks++; if (done2 !== 1'b0) begin errors++; $display("FAIL ovf_done got=%b want=0", done2); end
    checks++; if (bus2.mem_addr !== 2'd3) begin errors++; $display("FAIL ovf_mem_addr got=%0d want=3", bus2.mem_addr); end
    // Stuck in ERROR: offered field sets are ignored
    valid2 = 1'b1;
    repeat (4) tick();
    valid2 = 1'b0;
    checks++; if (bus2.in_ready !== 1'b0) begin errors++; $display("FAIL ovf_ready got=%b want=0", bus2.in_ready); end
    checks++; if (err2 !== 1'b1) begin errors++; $display("FAIL ovf_hold got=%b want=1", err2); end
  endtask

  task automatic test_back_to_back();
    pulse_start(1'b0);
    wcyc1.delete();
    send(1'b0, OpSlt, 2'd1, 2'd3, 8'd0, 1'b1, 0, 8'b10101110);
    send(1'b0, OpAddi, 2'd2, 2'd0, 8'd3, 1'b1, 1, 8'b01110011);
    send(1'b0, OpLoad, 2'd3, 2'd0, 8'hFF, 1'b1, 2, 8'b00011111);
    send(1'b0, OpAdd, 2'd0, 2'd1, 8'h80, 1'b1, 3, 8'b01000010);
    send(1'b0, OpBeq, 2'd1, 2'd0, 8'hFD, 1'b1, 4, 8'b10001101);
    send(1'b0, OpHalt, 2'd0, 2'd0, 8'd0, 1'b1, 5, 8'b11100000);
    drain(1'b0);
    tick();
    checks++; if (wcyc1.size() != 6) begin errors++; $display("FAIL b2b_writes got=%0d want=6", wcyc1.size()); end
    for (int k = 1; k < wcyc1.size(); k++) begin
      checks++;
      if (wcyc1[k] - wcyc1[k-1] != 2) begin
        errors++;
        $display("FAIL b2b_spacing got=%0d want=2", wcyc1[k] - wcyc1[k-1]);
      end
    end
    checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL b2b_done got=%b want=1", done1); end
    checks++; if (count1 !== 9'd6) begin errors++; $display("FAIL b2b_count got=%0d want=6", count1); end
  endtask

  task automatic test_restart();
    pulse_start(1'b0);
    send(1'b0, OpLoad, 2'd1, 2'd0, 8'd2, 1'b1, 0, 8'b00001010);
    send(1'b0, OpStore, 2'd2, 2'd0, 8'd3, 1'b1, 1, 8'b00110011);
    drain(1'b0);
    tick();
    checks++; if (count1 !== 9'd2) begin errors++; $display("FAIL rs_count_pre got=%0d want=2", count1); end
    pulse_start(1'b0);
    checks++; if (count1 !== 9'd0) begin errors++; $display("FAIL rs_count got=%0d want=0", count1); end
    checks++; if (bus1.mem_addr !== 8'd0) begin errors++; $display("FAIL rs_addr got=%0d want=0", bus1.mem_addr); end
    checks++; if (bus1.in_ready !== 1'b1) begin errors++; $display("FAIL rs_ready got=%b want=1", bus1.in_ready); end
    send(1'b0, OpLoad, 2'd0, 2'd0, 8'd1, 1'b1, 0, 8'b00000001);
    send(1'b0, OpHalt, 2'd0, 2'd0, 8'd0, 1'b1, 1, 8'b11100000);
    drain(1'b0);
    tick();
    checks++; if (count1 !== 9'd2) begin errors++; $display("FAIL rs_count_post got=%0d want=2", count1); end
  endtask

  task automatic test_reset_mid_write();
    pulse_start(1'b0);
    send(1'b0, OpLoad, 2'd1, 2'd0, 8'd2, 1'b0, 0, 8'h00);
    checks++; if (bus1.mem_we !== 1'b1) begin errors++; $display("FAIL mw_we_before got=%b want=1", bus1.mem_we); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus1.mem_we !== 1'b0) begin errors++; $display("FAIL mw_we got=%b want=0", bus1.mem_we); end
    checks++; if (bus1.mem_wdata !== 8'd0) begin errors++; $display("FAIL mw_wdata got=%h want=0", bus1.mem_wdata); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL mw_busy got=%b want=0", busy1); end
    checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL mw_done got=%b want=0", done1); end
    checks++; if (err2 !== 1'b0) begin errors++; $display("FAIL mw_err2 got=%b want=0", err2); end
    checks++; if (err_code2 !== 2'b00) begin errors++; $display("FAIL mw_err_code2 got=%b want=00", err_code2); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    start1 = 1'b0; start2 = 1'b0; valid1 = 1'b0; valid2 = 1'b0;
    op = '0; ra = '0; rb = '0; imm = '0;
    test_reset();
    test_program();
    test_imm_range();
    test_jump_range();
    test_overflow();
    test_back_to_back();
    test_restart();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nrisc_program_loader.md
# nrisc_program_loader

Writer side of the nRISC 8-bit instruction word. Accepts decoded instruction fields (opcode, register indices, signed immediate) from the host/assembler interface over a valid/ready handshake. Range-checks each immediate, packs the fields into the 8-bit instruction format consumed by fetch/decode and the sign extender, and writes the words sequentially into instruction memory from address 0. Loading ends on `halt` or on an error.

## Interface
- `ADDR_W`, 8, instruction memory address width (depth 2^ADDR_W)
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous active-low reset
- `start` in 1: pulse; (re)starts a load at address 0
- `in_valid` in 1: field set valid
- `in_ready` out 1: loader can accept a field set
- `in_op` in 3: opcode (000 load, 001 store, 010 add, 011 addi, 100 beq, 101 slt, 110 jump, 111 halt)
- `in_ra` in 2: first register index
- `in_rb` in 2: second register index (R-type only)
- `in_imm` in 8: signed immediate, two's complement
- `mem_we` out 1: instruction memory write strobe
- `mem_addr` out ADDR_W: write address
- `mem_wdata` out 8: encoded instruction
- `busy` out 1: state is LOAD or WRITE
- `done` out 1: halt written, load complete
- `err` out 1: load aborted
- `err_code` out 2: 00 none, 01 immediate out of range, 10 memory overflow
- `count` out ADDR_W+1: instructions written since last `start`

## Operation
- Formats, opcode always in [7:5]:
  - I-type (load, store, addi, beq): [4:3]=ra, [2:0]=imm, signed −4..3.
  - R-type (add, slt): [4:3]=ra, [2:1]=rb, [0]=0; imm ignored.
  - J-type (jump): [4:0]=imm, signed −16..15.
  - halt: [4:0]=00000.
- Range check: the field's sign-extension back to 8 bits must equal `in_imm`; otherwise err_code 01. Nothing is written and `mem_addr` is not advanced.
- States:
  - IDLE: on `start` go to LOAD; addr, count and err_code cleared.
  - LOAD: `in_ready`=1.
    - Handshake with an in-range immediate: latch `mem_wdata`, go to WRITE.
    - Handshake with an out-of-range immediate: go to ERROR, code 01.
  - WRITE: `mem_we`=1 at current `mem_addr`; count+1. Then:
    - halt → DONE.
    - Else `mem_addr` = all-ones → ERROR, code 10; the word is still written.
    - Else addr+1 → LOAD.
  - DONE / ERROR: hold all outputs; only `start` leaves, to LOAD.
- `start` has priority in every state. Next state is LOAD with addr/count/err_code cleared. A `start` in WRITE does not suppress that cycle's write (`mem_we` is a state output).
- Reset values: state IDLE, `in_ready` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, `busy` 0, `done` 0, `err` 0, `err_code` 00, `count` 0.

## Timing
- All outputs are registered or pure state decodes; there is no combinational path from inputs to outputs.
- Handshake:
  - Accepted at edge N.
  - `mem_we`=1 in cycle N+1 with the final `mem_addr`/`mem_wdata`.
  - `in_ready` high again in cycle N+2.
  - Throughput is one instruction per 2 cycles.
- `in_ready` is never high outside LOAD. `in_valid` while not ready is ignored and is not an error.
- `done` and `err` rise in the cycle after the final WRITE or the rejecting handshake. They are never high together.
- Reset asserted mid-WRITE: `mem_we` drops asynchronously, so no partial write is required.

## Structure
- Shared package `nrisc_isa_pkg`: opcode localparams, field bit positions, immediate ranges per format, err_code constants, loader state enum. The decoder and sign extender use the same package.
- Sub-module `nrisc_instr_encoder`: combinational fields → 8-bit word plus `imm_ok`. It is the exact inverse of the sign extender's field extraction.
- Top: FSM, address/count registers, output registers.

## Test plan
- `start`, then load ra=0 imm=1 / add ra=0 rb=2 / beq ra=2 imm=0 / jump imm=7 / halt → writes 00000001, 01000100, 10010000, 11000111, 11100000 at addr 0..4; `done`=1, `count`=5.
- addi ra=1 imm=−2 → 01101110. Then addi imm=4 → no write, `err`=1, `err_code`=01, `mem_addr` unchanged.
- jump imm=−16 accepted (11010000); jump imm=16 rejected with code 01.
- ADDR_W=2: four non-halt instructions → 4th written at addr 3, then `err_code`=10, `count`=4.
- `in_valid` held high continuously → `mem_we` pulses every other cycle; no handshake lost or duplicated.
- `start` during LOAD after 2 writes → `count`=0, next write at addr 0. `rst_n` low mid-WRITE → all outputs at reset values immediately.
